// File: rtl/vec_vrf_pkg.sv
// Shared VRF write-path definitions.
// Contents:
//   VRF_AW / VRF_DEPTH / VRF_XLEN : register file geometry
//   vrf_wr_req_t                  : one write-back request (address, bit enables, data)
//   rr_wrap()                     : wraps an index that has run past hi back to lo
package vec_vrf_pkg;

  localparam int unsigned VRF_AW    = 5;
  localparam int unsigned VRF_DEPTH = 32;
  localparam int unsigned VRF_XLEN  = 512;

  typedef struct packed {
    logic [VRF_AW-1:0]   addr;
    logic [VRF_XLEN-1:0] be;
    logic [VRF_XLEN-1:0] data;
  } vrf_wr_req_t;

  function automatic int unsigned rr_wrap(int unsigned idx, int unsigned lo, int unsigned hi);
    return (idx > hi) ? lo : idx;
  endfunction

endpackage

// File: rtl/vec_rr_pick.sv
// Combinational rotating-priority picker.
// Ports:
//   i_mask  : candidate request mask
//   i_start : index with highest priority; priority falls with increasing index, wrapping
//   o_pick  : one-hot winner (all zero when nothing is requested)
//   o_found : a winner exists
module vec_rr_pick #(
  parameter int unsigned N  = 5,
  parameter int unsigned SW = 3
) (
  input  logic [N-1:0]  i_mask,
  input  logic [SW-1:0] i_start,
  output logic [N-1:0]  o_pick,
  output logic          o_found
);

  logic [N-1:0] w_rot;
  logic [N-1:0] w_rot_pick;
  logic         w_found;

  // Rotate so that i_start lands on bit 0, then a plain lowest-bit search suffices.
  assign w_rot = N'({i_mask, i_mask} >> i_start);

  always_comb begin
    w_rot_pick = '0;
    w_found    = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      if (!w_found && w_rot[k]) begin
        w_rot_pick[k] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

  // Rotate the winner back into original index space.
  assign o_pick  = N'(({w_rot_pick, w_rot_pick} << i_start) >> N);
  assign o_found = w_found;

endmodule

// File: rtl/vec_vrf_wr_arb.sv
// VRF write-port arbiter.
// Requester 0 (single-cycle ALU) owns port 0; requesters 1..NREQ-1 share ports 1..WPORT-1
// round-robin. Requests whose address matches one already granted this cycle are deferred.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_hold              : VRF stall, no grants while high
//   i_req_valid/o_req_ready : per-requester handshake (ready is combinational)
//   i_req_addr/be/data  : flattened per-requester address, bit enable, data
//   o_wr_en/addr/be/data: registered, flattened VRF port signals (zero when idle)
//   o_conflict_cnt      : saturating count of cycles with an address-conflict deferral
module vec_vrf_wr_arb
  import vec_vrf_pkg::*;
#(
  parameter int unsigned NREQ  = 6,
  parameter int unsigned WPORT = 4,
  parameter int unsigned XLEN  = 512,
  parameter int unsigned AW    = VRF_AW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_hold,
  input  logic [NREQ-1:0]       i_req_valid,
  output logic [NREQ-1:0]       o_req_ready,
  input  logic [NREQ*AW-1:0]    i_req_addr,
  input  logic [NREQ*XLEN-1:0]  i_req_be,
  input  logic [NREQ*XLEN-1:0]  i_req_data,
  output logic [WPORT-1:0]      o_wr_en,
  output logic [WPORT*AW-1:0]   o_wr_addr,
  output logic [WPORT*XLEN-1:0] o_wr_be,
  output logic [WPORT*XLEN-1:0] o_wr_data,
  output logic [15:0]           o_conflict_cnt
);

  localparam int unsigned NRR = NREQ - 1;
  localparam int unsigned IW  = $clog2(NREQ);

  // RR-side vectors are indexed by requester - 1.
  logic [AW-1:0]         w_addr [NREQ];
  logic                  w_gnt0;
  logic [NRR-1:0]        w_cand, w_conf0, w_gnt_rr, w_conf_fin;
  logic [IW-1:0]         w_start, w_last, w_rr_ptr_d;
  logic                  w_exhausted, w_conf_evt;
  logic [WPORT-1:0]      w_en_d;
  logic [WPORT*AW-1:0]   w_addr_d;
  logic [WPORT*XLEN-1:0] w_be_d, w_data_d;

  logic [IW-1:0]         r_rr_ptr;
  logic [15:0]           r_conflict_cnt;
  logic [WPORT-1:0]      r_wr_en;
  logic [WPORT*AW-1:0]   r_wr_addr;
  logic [WPORT*XLEN-1:0] r_wr_be, r_wr_data;

  for (genvar i = 0; i < NREQ; i++) begin : g_addr
    assign w_addr[i] = i_req_addr[i*AW +: AW];
  end

  // Gating with rst_n keeps ready low while reset is asserted.
  assign w_gnt0  = rst_n & ~i_hold & i_req_valid[0];
  assign w_cand  = (rst_n & ~i_hold) ? i_req_valid[NREQ-1:1] : '0;
  assign w_start = r_rr_ptr - IW'(1);

  always_comb begin
    w_conf0 = '0;
    for (int j = 0; j < int'(NRR); j++) begin
      w_conf0[j] = w_gnt0 && (w_addr[j+1] == w_addr[0]);
    end
  end

  assign w_en_d[0]            = w_gnt0;
  assign w_addr_d[AW-1:0]     = w_gnt0 ? w_addr[0] : '0;
  assign w_be_d[XLEN-1:0]     = w_gnt0 ? i_req_be[XLEN-1:0] : '0;
  assign w_data_d[XLEN-1:0]   = w_gnt0 ? i_req_data[XLEN-1:0] : '0;

  // One picker per shared port. Each stage masks out earlier winners and any candidate whose
  // address matches an earlier grant, which reproduces a single in-order scan from the pointer.
  for (genvar p = 1; p < WPORT; p++) begin : g_stage
    logic [NRR-1:0]  w_used_in, w_conf_in, w_mask, w_pick, w_used_out, w_conf_out;
    logic [IW-1:0]   w_last_in, w_last_out;
    logic            w_found;
    logic [AW-1:0]   w_paddr;
    logic [XLEN-1:0] w_pbe, w_pdata;

    if (p == 1) begin : g_head
      assign w_used_in = '0;
      assign w_conf_in = w_conf0;
      assign w_last_in = '0;
    end else begin : g_link
      assign w_used_in = g_stage[p-1].w_used_out;
      assign w_conf_in = g_stage[p-1].w_conf_out;
      assign w_last_in = g_stage[p-1].w_last_out;
    end

    assign w_mask = w_cand & ~w_used_in & ~w_conf_in;

    vec_rr_pick #(
      .N  (NRR),
      .SW (IW)
    ) u_pick (
      .i_mask  (w_mask),
      .i_start (w_start),
      .o_pick  (w_pick),
      .o_found (w_found)
    );

    always_comb begin
      w_paddr    = '0;
      w_pbe      = '0;
      w_pdata    = '0;
      w_last_out = w_last_in;
      for (int j = 0; j < int'(NRR); j++) begin
        if (w_pick[j]) begin
          w_paddr    = w_addr[j+1];
          w_pbe      = i_req_be[(j+1)*XLEN +: XLEN];
          w_pdata    = i_req_data[(j+1)*XLEN +: XLEN];
          w_last_out = IW'(j + 1);
        end
      end
    end

    always_comb begin
      w_conf_out = w_conf_in;
      for (int j = 0; j < int'(NRR); j++) begin
        if (w_found && (w_addr[j+1] == w_paddr)) w_conf_out[j] = 1'b1;
      end
    end

    assign w_used_out               = w_used_in | w_pick;
    assign w_en_d[p]                = w_found;
    assign w_addr_d[p*AW +: AW]     = w_paddr;
    assign w_be_d[p*XLEN +: XLEN]   = w_pbe;
    assign w_data_d[p*XLEN +: XLEN] = w_pdata;
  end

  assign w_gnt_rr    = g_stage[WPORT-1].w_used_out;
  assign w_conf_fin  = g_stage[WPORT-1].w_conf_out;
  assign w_last      = g_stage[WPORT-1].w_last_out;
  assign w_exhausted = g_stage[WPORT-1].w_found;

  // A valid loser was actually reached by the scan (and so skipped for conflict) unless every
  // shared port was used and it sits after the last winner in scan order.
  always_comb begin
    int p_last;
    int p_j;
    w_conf_evt = 1'b0;
    p_last = (int'(w_last) - 1 + int'(NRR) - int'(w_start)) % int'(NRR);
    for (int j = 0; j < int'(NRR); j++) begin
      p_j = (j + int'(NRR) - int'(w_start)) % int'(NRR);
      if (w_cand[j] && !w_gnt_rr[j] && w_conf_fin[j] && (!w_exhausted || (p_j < p_last))) begin
        w_conf_evt = 1'b1;
      end
    end
  end

  always_comb begin
    w_rr_ptr_d = r_rr_ptr;
    if (w_last != '0) w_rr_ptr_d = IW'(rr_wrap(int'(w_last) + 1, 1, NRR));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en        <= '0;
      r_wr_addr      <= '0;
      r_wr_be        <= '0;
      r_wr_data      <= '0;
      r_rr_ptr       <= IW'(1);
      r_conflict_cnt <= '0;
    end else begin
      r_wr_en   <= w_en_d;
      r_wr_addr <= w_addr_d;
      r_wr_be   <= w_be_d;
      r_wr_data <= w_data_d;
      r_rr_ptr  <= w_rr_ptr_d;
      if (w_conf_evt && (r_conflict_cnt != 16'hFFFF)) begin
        r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end
    end
  end

  assign o_req_ready    = {w_gnt_rr, w_gnt0};
  assign o_wr_en        = r_wr_en;
  assign o_wr_addr      = r_wr_addr;
  assign o_wr_be        = r_wr_be;
  assign o_wr_data      = r_wr_data;
  assign o_conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_vec_vrf_wr_arb.sv
// Self-checking bench for vec_vrf_wr_arb: directed scenarios with literal expectations plus
// randomized traffic, all compared each cycle against an in-order scan reference model.
module tb_vec_vrf_wr_arb;

  localparam int NREQ  = 6;
  localparam int WPORT = 4;
  localparam int XLEN  = 512;
  localparam int AW    = 5;
  localparam int CW    = WPORT * XLEN;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  i_hold;
  logic [NREQ-1:0]       i_req_valid;
  logic [NREQ-1:0]       o_req_ready;
  logic [NREQ*AW-1:0]    i_req_addr;
  logic [NREQ*XLEN-1:0]  i_req_be, i_req_data;
  logic [WPORT-1:0]      o_wr_en;
  logic [WPORT*AW-1:0]   o_wr_addr;
  logic [WPORT*XLEN-1:0] o_wr_be, o_wr_data;
  logic [15:0]           o_conflict_cnt;

  always #5 clk = ~clk;

  vec_vrf_wr_arb #(
    .NREQ  (NREQ),
    .WPORT (WPORT),
    .XLEN  (XLEN),
    .AW    (AW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_hold         (i_hold),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_addr     (i_req_addr),
    .i_req_be       (i_req_be),
    .i_req_data     (i_req_data),
    .o_wr_en        (o_wr_en),
    .o_wr_addr      (o_wr_addr),
    .o_wr_be        (o_wr_be),
    .o_wr_data      (o_wr_data),
    .o_conflict_cnt (o_conflict_cnt)
  );

  // Requester state driven onto the DUT.
  logic            v [NREQ];
  logic [AW-1:0]   a [NREQ];
  logic [XLEN-1:0] b [NREQ];
  logic [XLEN-1:0] d [NREQ];
  logic            h;

  // Reference model state and expectations.
  int                    m_ptr = 1;
  int                    m_cnt = 0;
  logic [NREQ-1:0]       e_ready;
  logic [WPORT-1:0]      e_en;
  logic [WPORT*AW-1:0]   e_addr;
  logic [WPORT*XLEN-1:0] e_be, e_data;

  // DUT samples for the directed literal checks.
  logic [NREQ-1:0]       s_ready;
  logic [WPORT-1:0]      s_en;
  logic [WPORT*AW-1:0]   s_addr;
  logic [WPORT*XLEN-1:0] s_data;
  logic [15:0]           s_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    int fd;
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      fd = -1;
      for (int k = 0; k < CW; k++) if (fd < 0 && got[k] !== exp[k]) fd = k;
      $display("FAIL %s: got %h, expected %h (low 64 bits, first differing bit %0d) at %0t",
               nm, got[63:0], exp[63:0], fd, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] rnd_wide();
    logic [XLEN-1:0] r;
    for (int w = 0; w < XLEN / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) begin
      v[i] = 1'b0; a[i] = '0; b[i] = '0; d[i] = '0;
    end
  endtask

  task automatic drive();
    i_hold = h;
    for (int i = 0; i < NREQ; i++) begin
      i_req_valid[i]              = v[i];
      i_req_addr[i*AW +: AW]      = a[i];
      i_req_be[i*XLEN +: XLEN]    = b[i];
      i_req_data[i*XLEN +: XLEN]  = d[i];
    end
  endtask

  // One cycle of the arbitration rules: ALU to port 0, then a scan of 1..NREQ-1 from the
  // pointer handing out ports in order and skipping addresses already granted.
  task automatic model_step();
    logic [AW-1:0] gq[$];
    int port, last, idx;
    logic skipped, hit;
    e_ready = '0; e_en = '0; e_addr = '0; e_be = '0; e_data = '0;
    if (!h) begin
      if (v[0]) begin
        e_ready[0] = 1'b1; e_en[0] = 1'b1;
        e_addr[0 +: AW] = a[0]; e_be[0 +: XLEN] = b[0]; e_data[0 +: XLEN] = d[0];
        gq.push_back(a[0]);
      end
      port = 1; last = -1; skipped = 1'b0;
      for (int k = 0; k < NREQ - 1; k++) begin
        idx = 1 + (m_ptr - 1 + k) % (NREQ - 1);
        if (port < WPORT && v[idx]) begin
          hit = 1'b0;
          foreach (gq[q]) if (gq[q] == a[idx]) hit = 1'b1;
          if (hit) skipped = 1'b1;
          else begin
            e_ready[idx] = 1'b1; e_en[port] = 1'b1;
            e_addr[port*AW +: AW] = a[idx];
            e_be[port*XLEN +: XLEN] = b[idx];
            e_data[port*XLEN +: XLEN] = d[idx];
            gq.push_back(a[idx]);
            port++; last = idx;
          end
        end
      end
      if (last > 0) m_ptr = (last == NREQ - 1) ? 1 : last + 1;
      if (skipped && m_cnt < 65535) m_cnt++;
    end
  endtask

  // Entered at a falling edge with reset released; returns at the next falling edge.
  task automatic run_cycle();
    logic dup;
    drive();
    #1;
    model_step();
    s_ready = o_req_ready;
    chk("req_ready", CW'(s_ready), CW'(e_ready));
    @(posedge clk);
    #1;
    s_en = o_wr_en; s_addr = o_wr_addr; s_data = o_wr_data; s_cnt = o_conflict_cnt;
    chk("wr_en", CW'(s_en), CW'(e_en));
    chk("wr_addr", CW'(s_addr), CW'(e_addr));
    chk("wr_be", o_wr_be, e_be);
    chk("wr_data", s_data, e_data);
    chk("conflict_cnt", CW'(s_cnt), CW'(m_cnt));
    dup = 1'b0;
    for (int p = 0; p < WPORT; p++)
      for (int q = p + 1; q < WPORT; q++)
        if (s_en[p] && s_en[q] && s_addr[p*AW +: AW] == s_addr[q*AW +: AW]) dup = 1'b1;
    chk("addr_unique", CW'(dup), CW'(1'b0));
    @(negedge clk);
  endtask

  // Asynchronous reset in the low clock phase; outputs must clear without a clock edge.
  task automatic reset_dut();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst ready", CW'(o_req_ready), CW'(0));
    chk("rst wr_en", CW'(o_wr_en), CW'(0));
    chk("rst wr_addr", CW'(o_wr_addr), CW'(0));
    chk("rst wr_be", o_wr_be, CW'(0));
    chk("rst wr_data", o_wr_data, CW'(0));
    chk("rst conflict_cnt", CW'(o_conflict_cnt), CW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 1;
    m_cnt = 0;
  endtask

  initial begin
    h = 1'b0;
    clear_reqs();
    drive();
    @(negedge clk);
    reset_dut();

    // Single ALU write.
    v[0] = 1'b1; a[0] = 5'd3; b[0] = '1; d[0] = {64{8'hA5}};
    run_cycle();
    chk("alu ready", CW'(s_ready), CW'(6'b000001));
    chk("alu wr_en", CW'(s_en), CW'(4'b0001));
    chk("alu wr_addr", CW'(s_addr), CW'({5'd0, 5'd0, 5'd0, 5'd3}));
    chk("alu wr_data", s_data, CW'({64{8'hA5}}));
    clear_reqs();

    // Full contention among requesters 1..5.
    for (int i = 1; i < NREQ; i++) begin
      v[i] = 1'b1; a[i] = AW'(i); b[i] = rnd_wide(); d[i] = rnd_wide();
    end
    run_cycle();
    chk("contend c0 ready", CW'(s_ready), CW'(6'b001110));
    chk("contend c0 addr", CW'(s_addr), CW'({5'd3, 5'd2, 5'd1, 5'd0}));
    run_cycle();
    chk("contend c1 ready", CW'(s_ready), CW'(6'b110010));
    chk("contend c1 addr", CW'(s_addr), CW'({5'd1, 5'd5, 5'd4, 5'd0}));
    run_cycle();
    chk("contend c2 ready", CW'(s_ready), CW'(6'b011100));
    chk("contend c2 addr", CW'(s_addr), CW'({5'd4, 5'd3, 5'd2, 5'd0}));
    clear_reqs();

    // Address conflict with the ALU.
    v[0] = 1'b1; a[0] = 5'd7; v[1] = 1'b1; a[1] = 5'd7; v[2] = 1'b1; a[2] = 5'd9;
    b[1] = rnd_wide(); d[1] = rnd_wide();
    run_cycle();
    chk("conflict ready", CW'(s_ready), CW'(6'b000101));
    chk("conflict wr_en", CW'(s_en), CW'(4'b0011));
    chk("conflict addr", CW'(s_addr), CW'({5'd0, 5'd0, 5'd9, 5'd7}));
    chk("conflict cnt", CW'(s_cnt), CW'(16'd1));
    v[0] = 1'b0; v[2] = 1'b0;
    run_cycle();
    chk("deferred ready", CW'(s_ready), CW'(6'b000010));
    chk("deferred addr", CW'(s_addr), CW'({5'd0, 5'd0, 5'd7, 5'd0}));
    chk("deferred cnt", CW'(s_cnt), CW'(16'd1));
    clear_reqs();

    // Hold with everything valid.
    for (int i = 0; i < NREQ; i++) begin
      v[i] = 1'b1; a[i] = AW'(10 + i); b[i] = rnd_wide(); d[i] = rnd_wide();
    end
    h = 1'b1;
    for (int c = 0; c < 3; c++) begin
      run_cycle();
      chk("hold ready", CW'(s_ready), CW'(6'b000000));
      chk("hold wr_en", CW'(s_en), CW'(4'b0000));
    end
    h = 1'b0;
    run_cycle();
    chk("post-hold ready", CW'(s_ready), CW'(6'b011101));
    chk("post-hold wr_en", CW'(s_en), CW'(4'b1111));

    // Reset in the middle of traffic.
    run_cycle();
    chk("pre-reset wr_en", CW'(s_en), CW'(4'b1111));
    reset_dut();
    v[0] = 1'b0;
    run_cycle();
    chk("post-reset ready", CW'(s_ready), CW'(6'b001110));
    clear_reqs();

    // Randomized traffic; small address range to provoke conflicts.
    for (int i = 0; i < NREQ; i++) begin
      v[i] = ($urandom_range(0, 9) < 7); a[i] = AW'($urandom_range(0, 7));
      b[i] = rnd_wide(); d[i] = rnd_wide();
    end
    for (int c = 0; c < 2000; c++) begin
      run_cycle();
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i] || e_ready[i]) begin
          v[i] = ($urandom_range(0, 9) < 7);
          a[i] = AW'($urandom_range(0, 7));
          b[i] = rnd_wide();
          d[i] = rnd_wide();
        end
      end
      h = ($urandom_range(0, 9) == 0);
    end
    h = 1'b0;
    clear_reqs();

    // Counter saturation: requester 1 loses to the ALU on address every cycle.
    reset_dut();
    v[0] = 1'b1; a[0] = 5'd7; b[0] = '1; d[0] = rnd_wide();
    v[1] = 1'b1; a[1] = 5'd7; b[1] = '1; d[1] = rnd_wide();
    repeat (65534) run_cycle();
    chk("sat cnt 65534", CW'(s_cnt), CW'(16'hFFFE));
    run_cycle();
    chk("sat cnt 65535", CW'(s_cnt), CW'(16'hFFFF));
    repeat (3) run_cycle();
    chk("sat cnt held", CW'(s_cnt), CW'(16'hFFFF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vec_vrf_wr_arb.md
Name: vec_vrf_wr_arb

Overview:
- Write-port arbiter in front of the vector register file (32 x XLEN, WPORT write ports, bit-granular write enables).
- Collects write-back requests from NREQ execution units and maps them onto the WPORT VRF write ports each cycle.
- Port 0 is dedicated to requester 0, the single-cycle ALU. This is the only port the VRF read path forwards from.
- Ports 1..WPORT-1 are shared round-robin among requesters 1..NREQ-1. Same-register writes are never issued in the same cycle.

Parameters:
- NREQ, 6, number of write-back requesters (requester 0 = single-cycle ALU).
- WPORT, 4, number of VRF write ports (>=2).
- XLEN, 512, vector register width; write-enable is per bit.
- AW, 5, vector register address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- hold  in  1  VRF write stall; no grants while high.
- req_valid  in  [NREQ]  write request valid.
- req_ready  out  [NREQ]  request accepted this cycle (combinational).
- req_addr  in  [NREQ][AW]  destination vreg.
- req_be  in  [NREQ][XLEN]  per-bit write enable.
- req_data  in  [NREQ][XLEN]  write data.
- wr_en  out  [WPORT]  VRF port write enable (registered).
- wr_addr  out  [WPORT][AW]  VRF port address (registered).
- wr_be  out  [WPORT][XLEN]  VRF port bit enable (registered).
- wr_data  out  [WPORT][XLEN]  VRF port data (registered).
- conflict_cnt  out  16  saturating count of cycles with at least one address-conflict deferral.

Behaviour:
- Reset (async): all wr_* = 0, conflict_cnt = 0, RR pointer = 1. req_ready is combinational and therefore 0 during reset.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i]. req_ready[i] may depend on req_valid; requesters must not make valid depend on ready. A valid request holds addr/be/data stable until accepted.
- hold=1: all req_ready = 0, no transfer, RR pointer frozen, conflict_cnt unchanged. Next cycle wr_en = 0 and the other wr_* fields = 0.
- Port 0 grant: if hold=0 and req_valid[0], grant requester 0 to port 0. Otherwise port 0 is idle; it is never given to another requester.
- RR grant: with hold=0, scan requesters 1..NREQ-1 starting at the RR pointer, wrapping within 1..NREQ-1. Assign ports 1,2,...,WPORT-1 in scan order.
- Address-conflict rule: a candidate is skipped if its req_addr equals the address of any request already granted this cycle, including requester 0. The comparison ignores be. A skipped candidate remains valid and competes next cycle.
- Granting stops when ports 1..WPORT-1 are exhausted.
- RR pointer update: if at least one RR grant was made, pointer = (index of last RR-granted requester) + 1, wrapping NREQ-1 -> 1. Otherwise the pointer is unchanged.
- Latency: a request accepted in cycle T appears on wr_* at the rising edge ending T, i.e. visible in T+1. It is written into the VRF at the end of T+1.
- Ports not granted in T are driven next cycle with wr_en = 0 and addr/be/data = 0.
- conflict_cnt: increments by 1 in each cycle where at least one valid candidate was skipped solely for address conflict. It saturates at 16'hFFFF.
- Starvation bound: a continuously valid requester 1..NREQ-1 with no address conflict is granted within ceil((NREQ-1)/(WPORT-1)) non-hold cycles.
- Same-cycle invariant on wr_*: no two enabled ports carry the same wr_addr.

Decomposition:
- Package vec_vrf_pkg:
  - VRF_AW = 5, VRF_DEPTH = 32.
  - Typedef vrf_wr_req_t = struct {addr[AW], be[XLEN], data[XLEN]}.
  - Function rr_wrap(idx, lo, hi).
- Sub-module vec_rr_pick: combinational rotating-priority picker.
  - Inputs: request mask, start pointer.
  - Outputs: one-hot pick, found flag.
  - Used iteratively WPORT-1 times, masking out earlier picks and conflicting addresses.

Test Plan (defaults NREQ=6, WPORT=4):
- Single ALU write: req0 valid, addr=3, be=all-ones, data=0xA5... -> req_ready[0]=1 in the same cycle; next cycle wr_en=4'b0001, wr_addr[0]=3, wr_data[0]=0xA5..., other ports all-zero.
- Full contention: req1..5 valid continuously, distinct addrs 1..5, pointer=1.
  - Cycle 0: grants req1,2,3 -> ports 1,2,3; pointer becomes 4.
  - Cycle 1: grants req4,5,1; pointer becomes 2.
  - Cycle 2: grants req2,3,4.
- Address conflict: req0 addr=7, req1 addr=7, req2 addr=9 -> ready = 6'b000101; ports 0,1 carry addr 7 and 9; conflict_cnt 0->1; req1 granted the next cycle once req0 drops.
- Hold: all valid with hold=1 for 3 cycles -> req_ready=0 and wr_en=0 for those cycles; pointer unchanged; after release the first grants start at the pre-hold pointer.
- Reset mid-traffic: assert rst_n=0 asynchronously with wr_en=4'b1111 -> wr_* clear immediately, conflict_cnt=0; first post-reset RR grant goes to req1.
- Saturation: force 65536 consecutive conflict cycles -> conflict_cnt holds 16'hFFFF.
